// File: rtl/pipe_pkg.sv
// Shared definitions for the elastic pipeline stage buffer.
//   pipe_state_e  : fill level of a stage buffer (EMPTY / ONE / TWO); the
//                   encoding equals the number of entries held so it can be
//                   exported directly as an occupancy count.
//   PIPE_STALL_CW : default width of the saturating stall counter.
package pipe_pkg;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } pipe_state_e;

    localparam int PIPE_STALL_CW = 16;

endpackage

// File: rtl/pipe_stage_buf.sv
// Elastic pipeline stage register with valid/ready handshake on both sides,
// synchronous flush, optional skid slot and a saturating stall counter.
//
// Parameters
//   WIDTH     : payload width (use $bits() of the stage struct)
//   SKID      : 0 = single entry, in_ready depends combinationally on out_ready
//               1 = two entries, in_ready is a function of registered state only
//   RESET_VAL : out_data value after reset and whenever the buffer is empty
//   STALL_CW  : stall counter width
//
// Ports
//   clk, rst           : clock, synchronous active-high reset
//   in_valid/in_ready  : upstream handshake, in_data is the payload
//   flush              : discard everything held and incoming this cycle
//   out_valid/out_ready: downstream handshake, out_data is the head payload
//   occupancy          : entries currently held (0..1 or 0..2)
//   stall_cnt          : cycles with out_valid && !out_ready, saturating
module pipe_stage_buf
    import pipe_pkg::*;
#(
    parameter int                 WIDTH     = 32,
    parameter int                 SKID      = 0,
    parameter logic [WIDTH-1:0]   RESET_VAL = '0,
    parameter int                 STALL_CW  = PIPE_STALL_CW
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     in_data,
    input  logic                 flush,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [WIDTH-1:0]     out_data,
    output logic [1:0]           occupancy,
    output logic [STALL_CW-1:0]  stall_cnt
);

    pipe_state_e        r_state;
    pipe_state_e        w_state_next;
    logic [WIDTH-1:0]   r_head;
    logic [WIDTH-1:0]   w_head_next;
    logic [WIDTH-1:0]   w_skid;
    logic               w_head_load;
    logic               w_head_from_skid;
    logic               w_in_xfer;
    logic               w_out_xfer;
    logic [STALL_CW-1:0] r_stall;

    assign out_valid  = (r_state != EMPTY) && !flush;
    assign out_data   = (r_state == EMPTY) ? RESET_VAL : r_head;
    assign occupancy  = r_state;
    assign stall_cnt  = r_stall;

    assign w_in_xfer  = in_valid && in_ready;
    assign w_out_xfer = out_valid && out_ready;

    generate
        if (SKID != 0) begin : g_skid
            logic [WIDTH-1:0] r_skid;

            // Ready only looks at the registered fill level, which breaks the
            // combinational out_ready -> in_ready path between stages.
            assign in_ready = !rst && !flush && (r_state != TWO);

            // The skid slot captures the extra payload accepted while the
            // head is blocked downstream.
            always_ff @(posedge clk) begin
                if (rst) begin
                    r_skid <= RESET_VAL;
                end else if ((r_state == ONE) && w_in_xfer && !w_out_xfer) begin
                    r_skid <= in_data;
                end
            end

            assign w_skid = r_skid;
        end else begin : g_noskid
            // Single entry: a full buffer can only take a new payload when the
            // head leaves in the same cycle.
            assign in_ready = !rst && !flush && ((r_state == EMPTY) || out_ready);
            assign w_skid   = RESET_VAL;
        end
    endgenerate

    always_comb begin
        w_state_next     = r_state;
        w_head_load      = 1'b0;
        w_head_from_skid = 1'b0;
        if (flush) begin
            w_state_next = EMPTY;
        end else begin
            case (r_state)
                EMPTY: begin
                    if (w_in_xfer) begin
                        w_state_next = ONE;
                        w_head_load  = 1'b1;
                    end
                end
                ONE: begin
                    if (w_in_xfer && w_out_xfer) begin
                        w_head_load = 1'b1;
                    end else if (w_out_xfer) begin
                        w_state_next = EMPTY;
                    end else if (w_in_xfer && (SKID != 0)) begin
                        w_state_next = TWO;
                    end
                end
                TWO: begin
                    if (w_out_xfer) begin
                        w_state_next     = ONE;
                        w_head_from_skid = 1'b1;
                    end
                end
                default: begin
                    w_state_next = EMPTY;
                end
            endcase
        end
    end

    assign w_head_next = w_head_from_skid ? w_skid : in_data;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= EMPTY;
            r_head  <= RESET_VAL;
        end else begin
            r_state <= w_state_next;
            if (w_head_load || w_head_from_skid) begin
                r_head <= w_head_next;
            end
        end
    end

    // Stall counter survives flush; only reset clears it.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_stall <= '0;
        end else if (out_valid && !out_ready && (r_stall != '1)) begin
            r_stall <= r_stall + 1'b1;
        end
    end

endmodule
